// File: rtl/fifo_pkg.sv
// Shared definitions for the cell-based FIFO: default depth, zone encoding, count width.
package fifo_pkg;

  localparam int unsigned DEFAULT_N_CELLS = 16;

  typedef enum logic [1:0] {
    Z_EMPTY = 2'b00,
    Z_NORM  = 2'b01,
    Z_FULL  = 2'b10
  } zone_e;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced recursive adder tree.
module popcount_tree
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned OUT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] cnt_c
);

  if (WIDTH == 1) begin : g_leaf
    // A single bit is its own count.
    assign cnt_c = bits_i;
  end else begin : g_node
    localparam int unsigned LO_W  = WIDTH / 2;
    localparam int unsigned HI_W  = WIDTH - LO_W;
    localparam int unsigned LO_CW = cnt_width(LO_W);
    localparam int unsigned HI_CW = cnt_width(HI_W);

    logic [LO_CW-1:0] lo_cnt;
    logic [HI_CW-1:0] hi_cnt;

    popcount_tree #(.WIDTH(LO_W)) u_lo (
      .bits_i (bits_i[LO_W-1:0]),
      .cnt_c  (lo_cnt)
    );

    popcount_tree #(.WIDTH(HI_W)) u_hi (
      .bits_i (bits_i[WIDTH-1:LO_W]),
      .cnt_c  (hi_cnt)
    );

    // Sum the two half-counts at the full output width.
    assign cnt_c = OUT_W'(lo_cnt) + OUT_W'(hi_cnt);
  end

endmodule

// File: rtl/fifo_occupancy_monitor.sv
// Registered occupancy count, zone tracking with hysteretic almost flags,
// and sticky misuse detection for the cell-based FIFO.
module fifo_occupancy_monitor
  import fifo_pkg::*;
#(
  parameter  int unsigned N_CELLS  = DEFAULT_N_CELLS,
  parameter  int unsigned AF_LEVEL = 12,
  parameter  int unsigned AE_LEVEL = 4,
  parameter  int unsigned HYST     = 2,
  localparam int unsigned CNT_W    = cnt_width(N_CELLS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_CELLS-1:0] f_i,
  input  logic               put,
  input  logic               get,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_CELLS);
  localparam logic [CNT_W-1:0] AF_SET   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AF_CLR   = CNT_W'(AF_LEVEL - HYST);
  localparam logic [CNT_W-1:0] AE_SET   = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] AE_CLR   = CNT_W'(AE_LEVEL + HYST);

  logic [CNT_W-1:0] next_count;
  zone_e            zone_q, zone_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  popcount_tree #(.WIDTH(N_CELLS)) u_popcount (
    .bits_i (f_i),
    .cnt_c  (next_count)
  );

  // State and flag registers; reset lands in the empty zone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zone_q  <= Z_EMPTY;
      count_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      zone_q  <= zone_d;
      count_q <= count_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Zone is chosen purely from the freshly sampled count.
  always_comb begin
    zone_d = Z_NORM;
    if (next_count == FULL_CNT) begin
      zone_d = Z_FULL;
    end else if (next_count == '0) begin
      zone_d = Z_EMPTY;
    end
  end

  // Almost flags with hysteresis (end zones override), plus sticky errors where set beats clear.
  always_comb begin
    count_d = next_count;
    af_d    = af_q;
    ae_d    = ae_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (next_count >= AF_SET) begin
      af_d = 1'b1;
    end else if (next_count < AF_CLR) begin
      af_d = 1'b0;
    end

    if (next_count <= AE_SET) begin
      ae_d = 1'b1;
    end else if (next_count > AE_CLR) begin
      ae_d = 1'b0;
    end

    if (zone_d == Z_FULL) begin
      af_d = 1'b1;
      ae_d = 1'b0;
    end else if (zone_d == Z_EMPTY) begin
      af_d = 1'b0;
      ae_d = 1'b1;
    end

    // Simultaneous put and get leaves occupancy unchanged, so it is not misuse.
    if (put && !get && full) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end

    if (get && !put && empty) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end
  end

  assign count        = count_q;
  assign full         = (zone_q == Z_FULL);
  assign empty        = (zone_q == Z_EMPTY);
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_occupancy_monitor.sv
// Scoreboard bench for fifo_occupancy_monitor with default parameters.
module tb_fifo_occupancy_monitor;

  typedef struct packed {
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] f_i;
  logic        put, get, clr_err;
  logic [4:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  exp_t  sb_q[$];
  string name_q[$];
  int    total  = 0;
  int    passed = 0;

  fifo_occupancy_monitor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .f_i          (f_i),
    .put          (put),
    .get          (get),
    .clr_err      (clr_err),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int c, input bit fu, input bit em, input bit af,
                              input bit ae, input bit ov, input bit un);
    exp_t e;
    e.count = 5'(c);
    e.full  = fu;
    e.empty = em;
    e.af    = af;
    e.ae    = ae;
    e.ovf   = ov;
    e.udf   = un;
    return e;
  endfunction

  function automatic logic [15:0] ones(input int k);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < k; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.count = count;
    a.full  = full;
    a.empty = empty;
    a.af    = almost_full;
    a.ae    = almost_empty;
    a.ovf   = overflow;
    a.udf   = underflow;
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got cnt=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b, want cnt=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b",
               name, act.count, act.full, act.empty, act.af, act.ae, act.ovf, act.udf,
               exp.count, exp.full, exp.empty, exp.af, exp.ae, exp.ovf, exp.udf);
    end
  endtask

  // Apply one vector for the coming edge and queue what the outputs must show after it.
  task automatic drive(input string name, input logic [15:0] f, input logic p, input logic g,
                       input logic c, input exp_t e);
    @(negedge clk);
    #1;
    f_i     = f;
    put     = p;
    get     = g;
    clr_err = c;
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = name_q.pop_front();
        check(n, actual(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    f_i     = '0;
    put     = 1'b0;
    get     = 1'b0;
    clr_err = 1'b0;
    #12;
    check("reset_initial", actual(), mk(0, 0, 1, 0, 1, 0, 0));
    #1 reset_n = 1'b1;

    // Fill ramp: ae drops once count exceeds 6, af rises at 12, full at 16.
    for (int k = 0; k <= 16; k++)
      drive($sformatf("fill_%0d", k), ones(k), 0, 0, 0,
            mk(k, k == 16, k == 0, k >= 12, k <= 6, 0, 0));

    // Drain: af holds down to 10 and clears at 9, ae returns at 4.
    for (int k = 16; k >= 0; k--)
      drive($sformatf("drain_%0d", k), ones(k), 0, 0, 0,
            mk(k, k == 16, k == 0, k >= 10, k <= 4, 0, 0));

    // Jumps of arbitrary size, including a non-contiguous pattern.
    drive("jump_zero",  16'h0000, 0, 0, 0, mk(0,  0, 1, 0, 1, 0, 0));
    drive("jump_full",  16'hFFFF, 0, 0, 0, mk(16, 1, 0, 1, 0, 0, 0));
    drive("jump_half",  16'h00FF, 0, 0, 0, mk(8,  0, 0, 0, 0, 0, 0));
    drive("jump_a5a5",  16'hA5A5, 0, 0, 0, mk(8,  0, 0, 0, 0, 0, 0));
    drive("jump_12",    16'h0FFF, 0, 0, 0, mk(12, 0, 0, 1, 0, 0, 0));
    drive("hold_af_10", 16'h03FF, 0, 0, 0, mk(10, 0, 0, 1, 0, 0, 0));
    drive("drop_af_6",  16'h003F, 0, 0, 0, mk(6,  0, 0, 0, 0, 0, 0));
    drive("set_ae_4",   16'h000F, 0, 0, 0, mk(4,  0, 0, 0, 1, 0, 0));
    drive("hold_ae_6",  16'h003F, 0, 0, 0, mk(6,  0, 0, 0, 1, 0, 0));

    // Overflow handling while full.
    drive("ovf_fill",     16'hFFFF, 0, 0, 0, mk(16, 1, 0, 1, 0, 0, 0));
    drive("ovf_put",      16'hFFFF, 1, 0, 0, mk(16, 1, 0, 1, 0, 1, 0));
    drive("ovf_sticky",   16'hFFFF, 0, 0, 0, mk(16, 1, 0, 1, 0, 1, 0));
    drive("ovf_clr",      16'hFFFF, 0, 0, 1, mk(16, 1, 0, 1, 0, 0, 0));
    drive("ovf_put_get",  16'hFFFF, 1, 1, 0, mk(16, 1, 0, 1, 0, 0, 0));
    drive("ovf_clr_put",  16'hFFFF, 1, 0, 1, mk(16, 1, 0, 1, 0, 1, 0));
    drive("ovf_clr2",     16'hFFFF, 0, 0, 1, mk(16, 1, 0, 1, 0, 0, 0));

    // Underflow handling while empty.
    drive("udf_drain",    16'h0000, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0));
    drive("udf_get",      16'h0000, 0, 1, 0, mk(0, 0, 1, 0, 1, 0, 1));
    drive("udf_sticky",   16'h0000, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 1));
    drive("udf_clr",      16'h0000, 0, 0, 1, mk(0, 0, 1, 0, 1, 0, 0));
    drive("udf_put_get",  16'h0000, 1, 1, 0, mk(0, 0, 1, 0, 1, 0, 0));
    drive("udf_clr_get",  16'h0000, 0, 1, 1, mk(0, 0, 1, 0, 1, 0, 1));
    drive("udf_clr2",     16'h0000, 0, 0, 1, mk(0, 0, 1, 0, 1, 0, 0));
    drive("udf_pre_rst",  16'h0000, 0, 1, 0, mk(0, 0, 1, 0, 1, 0, 1));

    // Let the monitor consume everything before the asynchronous reset.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    f_i = 16'hFFFF;
    get = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async", actual(), mk(0, 0, 1, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held", actual(), mk(0, 0, 1, 0, 1, 0, 0));
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    sb_q.push_back(mk(16, 1, 0, 1, 0, 0, 0));
    name_q.push_back("post_reset");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    total++;
    if (sb_q.size() != 0)
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_occupancy_monitor.md
Name: fifo_occupancy_monitor

Overview:
- Parametrised, registered successor to the combinational all-cells-full detector for the cell-based FIFO.
- Samples the per-cell full flags f_i and computes the occupancy count.
- Tracks an occupancy zone FSM with programmable almost-full/almost-empty thresholds and hysteresis.
- Flags overflow and underflow misuse against the put/get strobes. Sits beside the FIFO cell array and feeds the sender/receiver flow-control logic.

Parameters:
- N_CELLS, 16, number of FIFO cells (width of f_i); legal range 2..256.
- AF_LEVEL, 12, count at or above which almost_full asserts; 1 <= AF_LEVEL <= N_CELLS-1.
- AE_LEVEL, 4, count at or below which almost_empty asserts; 1 <= AE_LEVEL < AF_LEVEL.
- HYST, 2, hysteresis in cells for the almost flags; 0 <= HYST <= AE_LEVEL and HYST <= N_CELLS-1-AF_LEVEL.
- CNT_W, $clog2(N_CELLS+1), width of the count output (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_i  in  N_CELLS  per-cell full flags from the FIFO cells (1 = cell holds data).
- put  in  1  sender writes a token this cycle.
- get  in  1  receiver reads a token this cycle.
- clr_err  in  1  synchronous clear of the sticky error flags.
- count  out  CNT_W  registered popcount of f_i.
- full  out  1  registered; count == N_CELLS.
- empty  out  1  registered; count == 0.
- almost_full  out  1  registered, with hysteresis.
- almost_empty  out  1  registered, with hysteresis.
- overflow  out  1  sticky; put was seen while full.
- underflow  out  1  sticky; get was seen while empty.

Behaviour:
- Reset (reset_n low, asynchronous, any time): count=0, zone=Z_EMPTY, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. Outputs stay at these values until the first clk edge after reset_n rises. Reset mid-operation discards all state.
- Latency: count, full and empty reflect f_i sampled at the previous rising edge (1-cycle latency). f_i is a level input; no synchroniser is inside this block.
- count: popcount of f_i, unsigned, CNT_W bits. It cannot overflow by construction.
- Zone FSM, with next state computed from next_count = popcount(f_i):
  - Z_FULL when next_count == N_CELLS.
  - Z_EMPTY when next_count == 0.
  - Otherwise Z_NORM. Z_EMPTY and Z_FULL override the hysteresis flags.
- almost_full:
  - Sets when next_count >= AF_LEVEL.
  - Clears only when next_count < AF_LEVEL-HYST.
  - Holds otherwise.
  - Forced 1 in Z_FULL.
- almost_empty:
  - Sets when next_count <= AE_LEVEL.
  - Clears only when next_count > AE_LEVEL+HYST.
  - Holds otherwise.
  - Forced 1 in Z_EMPTY.
- HYST=0 gives plain threshold compares.
- Jumps of any size between cycles are legal. The flags are evaluated against next_count only, never incrementally.
- overflow sets on a clock edge where put=1 and registered full=1.
- underflow sets on a clock edge where get=1 and registered empty=1.
- put and get in the same cycle while full: overflow is not flagged (net occupancy is unchanged). The same exemption applies while empty for underflow.
- Flags are sticky until clr_err=1 or reset. If clr_err and a new error event occur in the same cycle, the flag is set (set wins).
- full and empty are never both 1 (N_CELLS >= 2).

Decomposition:
- Shared package fifo_pkg holds:
  - the zone encoding typedef: Z_EMPTY=2'b00, Z_NORM=2'b01, Z_FULL=2'b10;
  - the CNT_W derivation function;
  - the default N_CELLS constant shared with the cell array and the existing full detector.
- One sub-module, popcount_tree (parameter WIDTH). It is a combinational adder tree returning $clog2(WIDTH+1) bits and is reused by the empty/full detectors.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle with f_i=16'hFFFF. Required: count=0, empty=1, almost_empty=1, full=0, error flags 0 immediately. After release, one edge later: count=16, full=1, almost_full=1.
- Fill ramp: f_i steps 0 to 16 cells, one more per cycle, with defaults. Required:
  - almost_empty drops at count 7 (>4+2);
  - almost_full rises at count 12;
  - full rises at 16, each one cycle after the f_i change.
- Hysteresis drain: from 16 step down to 0. Required:
  - full drops at 15;
  - almost_full holds through 10 and drops at 9 (<12-2);
  - almost_empty rises at 4;
  - empty rises at 0.
- Jump: f_i 16'h0000 -> 16'hFFFF -> 16'h00FF on consecutive cycles. Required: (empty,ae)=(1,1), then (full,af)=(1,1), then count=8, af=0, ae=0.
- Errors, with full asserted:
  - put=1 alone -> overflow=1 next edge, persists;
  - put=1,get=1 while full -> no new set;
  - clr_err=1 with put=1 while full -> overflow stays 1;
  - clr_err=1 alone -> overflow=0;
  - mirror all four with get/empty/underflow.
